// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, PC defaults
// and bubble constants. The optional misaligned-redirect trap is controlled
// by the MISALIGN_TRAP_EN macro (see fetch_sequencer.sv).
package fetch_sequencer_pkg;

  // Sequencer states
  localparam logic [2:0] ST_BOOT  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;

  // Bubble: no valid instruction handed to decode, no squash
  localparam logic BUBBLE_VALID = 1'b0;
  localparam logic BUBBLE_FLUSH = 1'b0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // A fetch target must be word aligned
  function automatic logic addr_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_redirect_buffer.sv
// Holds a redirect target that arrived while a wrong-path fetch was still
// in flight. A new load always overwrites (youngest target wins) and takes
// priority over a clear issued in the same cycle.
module fetch_redirect_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  logic        clear,
  output logic        pend_valid,
  output logic [31:0] pend_addr
);

  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_addr_q, pend_addr_d;

  // Next-state: load overwrites, clear drops the valid bit
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    if (load) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = load_addr;
    end else if (clear) begin
      pend_valid_d = 1'b0;
    end
  end

  // Pending-target register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 32'h0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  assign pend_valid = pend_valid_q;
  assign pend_addr  = pend_addr_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, drives the next-PC mux select/target and
// handshakes with instruction memory. Priority: reset > redirect > stall >
// sequential advance.
// Optional feature macro: MISALIGN_TRAP_EN -- a misaligned redirect raises
// sticky misalignErr and parks the sequencer in HALT until reset. Without it
// targetAddr is forced word aligned.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectAddr,
  input  logic [31:0] pcNext,
  input  logic        imemReady,
  output logic        imemReq,
  output logic [31:0] pc,
  output logic [31:0] pcPlusFour,
  output logic [31:0] targetAddr,
  output logic        pcSrc,
  output logic        instValid,
  output logic        flush
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalignErr
`endif
);

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid, pend_load, pend_clear;
  logic [31:0] pend_addr, target_sel;
  logic        imem_req, inst_valid, flush_int;

  fetch_redirect_buffer u_redirect_buffer (
    .clk       (clk),
    .reset     (reset),
    .load      (pend_load),
    .load_addr (redirectAddr),
    .clear     (pend_clear),
    .pend_valid(pend_valid),
    .pend_addr (pend_addr)
  );

  assign pcPlusFour = pc_q + PC_STEP;
  assign pcSrc      = redirect | pend_valid;
  assign target_sel = pend_valid ? pend_addr : redirectAddr;

`ifdef MISALIGN_TRAP_EN
  logic err_q, err_d, trap;

  // A misaligned redirect from any active state traps; the faulting target
  // is steered through the mux so the PC records it.
  assign trap = redirect && addr_misaligned(redirectAddr) &&
                (state_q == ST_FETCH || state_q == ST_DRAIN || state_q == ST_HOLD);
  assign targetAddr  = trap ? redirectAddr : target_sel;
  assign misalignErr = err_q;
`else
  logic unused_target_bits;
  assign unused_target_bits = ^target_sel[1:0];
  assign targetAddr = {target_sel[31:2], 2'b00};
`endif

  // Sequencer next-state, PC update and per-cycle handshake outputs
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_load  = 1'b0;
    pend_clear = 1'b0;
    imem_req   = 1'b0;
    inst_valid = BUBBLE_VALID;
    flush_int  = BUBBLE_FLUSH;
`ifdef MISALIGN_TRAP_EN
    err_d = err_q;
`endif
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          flush_int = 1'b1;
          if (imemReady) begin
            pc_d = pcNext;
          end else begin
            pend_load = 1'b1;
            state_d   = ST_DRAIN;
          end
        end else if (imemReady) begin
          if (stall) begin
            state_d = ST_HOLD;
          end else begin
            inst_valid = 1'b1;
            pc_d       = pcNext;
          end
        end
      end
      ST_DRAIN: begin
        // The wrong-path fetch completes; its word is discarded. A redirect
        // arriving alongside completion keeps us draining toward it.
        imem_req = 1'b1;
        if (redirect) begin
          flush_int = 1'b1;
          pend_load = 1'b1;
        end
        if (imemReady) begin
          pc_d = pcNext;
          if (!redirect) begin
            pend_clear = 1'b1;
            state_d    = ST_FETCH;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          flush_int = 1'b1;
          pc_d      = pcNext;
          state_d   = ST_FETCH;
        end else if (!stall) begin
          state_d = ST_FETCH;
        end
      end
`ifdef MISALIGN_TRAP_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_BOOT;
    endcase
`ifdef MISALIGN_TRAP_EN
    if (trap) begin
      state_d    = ST_HALT;
      pc_d       = pcNext;
      err_d      = 1'b1;
      pend_load  = 1'b0;
      pend_clear = 1'b1;
      inst_valid = BUBBLE_VALID;
      flush_int  = 1'b1;
    end
`endif
  end

  // State and PC registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
`ifdef MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef MISALIGN_TRAP_EN
      err_q   <= err_d;
`endif
    end
  end

  // Reset suppresses every handshake output in the cycle it is asserted
  assign imemReq   = imem_req & ~reset;
  assign instValid = inst_valid & ~reset;
  assign flush     = flush_int & ~reset;
  assign pc        = pc_q;

endmodule
